// File: rtl/phys_reg_free_list.sv
// ============================================================================
// phys_reg_free_list : circular free list of physical registers for rename,
//                      with speculative/committed heads for flush recovery.
// Rev 1.0
// ============================================================================
`default_nettype none

module phys_reg_free_list #(
  parameter int PHYS_REGS     = 64,
  parameter int ARCH_REGS     = 32,
  parameter int ALLOC_WIDTH   = 2,
  parameter int RELEASE_WIDTH = 2,
  localparam int PW    = $clog2(PHYS_REGS),
  localparam int DEPTH = PHYS_REGS - ARCH_REGS,
  localparam int IW    = $clog2(DEPTH),
  localparam int PTRW  = IW + 1,
  localparam int FCW   = $clog2(DEPTH + 1),
  localparam int CCW   = $clog2(ALLOC_WIDTH + 1),
  localparam int RCW   = $clog2(RELEASE_WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ALLOC_WIDTH-1:0]      alloc_req,
  output logic                        alloc_gnt,
  output logic [ALLOC_WIDTH*PW-1:0]   alloc_reg,
  input  logic [RELEASE_WIDTH-1:0]    release_valid,
  input  logic [RELEASE_WIDTH*PW-1:0] release_reg,
  input  logic [CCW-1:0]              commit_count,
  input  logic                        flush,
  output logic [FCW-1:0]              free_count,
  output logic                        empty,
  output logic                        err
);

  logic [PW-1:0]   r_entries [DEPTH];
  logic [PTRW-1:0] r_spec_head;
  logic [PTRW-1:0] r_commit_head;
  logic [PTRW-1:0] r_tail;
  logic            r_err;

  logic [CCW-1:0]  w_alloc_n;
  logic [PTRW-1:0] w_aofs;
  logic [PTRW-1:0] w_aidx;
  logic [RCW-1:0]  w_rel_n;
  logic [PTRW-1:0] w_ridx;
  logic [IW-1:0]   w_rel_idx [RELEASE_WIDTH];
  logic            w_rel_bad;
  logic [PTRW-1:0] w_commit_next;
  logic [PTRW-1:0] w_live;
  logic [PTRW-1:0] w_in_flight;
  logic            w_overflow;
  logic            w_commit_bad;

  assign free_count = FCW'(r_tail - r_spec_head);
  assign empty      = (free_count == '0);
  assign err        = r_err;

  always_comb begin
    w_alloc_n = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      w_alloc_n = w_alloc_n + CCW'(alloc_req[i]);
    end
  end

  // Gated by rst_n so nothing is granted while reset is held.
  assign alloc_gnt = rst_n & (w_alloc_n != '0) & (free_count >= FCW'(w_alloc_n)) & ~flush;

  // Requesting lanes take consecutive entries from spec_head in lane order.
  always_comb begin
    alloc_reg = '0;
    w_aofs    = '0;
    w_aidx    = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      w_aidx = r_spec_head + w_aofs;
      if (alloc_req[i]) begin
        alloc_reg[i*PW +: PW] = r_entries[w_aidx[IW-1:0]];
        w_aofs = w_aofs + PTRW'(1);
      end
    end
  end

  // Valid release lanes are compacted and land at tail, tail+1, ...
  always_comb begin
    w_rel_n   = '0;
    w_rel_bad = 1'b0;
    w_ridx    = '0;
    for (int j = 0; j < RELEASE_WIDTH; j++) begin
      w_ridx       = r_tail + PTRW'(w_rel_n);
      w_rel_idx[j] = w_ridx[IW-1:0];
      if (release_valid[j]) begin
        w_rel_n = w_rel_n + RCW'(1);
        if (release_reg[j*PW +: PW] < PW'(ARCH_REGS)) begin
          w_rel_bad = 1'b1;
        end
      end
    end
  end

  assign w_commit_next = r_commit_head + PTRW'(commit_count);
  assign w_live        = r_tail - r_commit_head;
  assign w_in_flight   = r_spec_head - r_commit_head;
  assign w_overflow    = ({1'b0, w_live} + (PTRW+1)'(w_rel_n)) > (PTRW+1)'(DEPTH);
  assign w_commit_bad  = PTRW'(commit_count) > w_in_flight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= PW'(ARCH_REGS + i);
      end
      r_spec_head   <= '0;
      r_commit_head <= '0;
      r_tail        <= PTRW'(DEPTH);
      r_err         <= 1'b0;
    end else begin
      for (int j = 0; j < RELEASE_WIDTH; j++) begin
        if (release_valid[j]) begin
          r_entries[w_rel_idx[j]] <= release_reg[j*PW +: PW];
        end
      end
      r_tail        <= r_tail + PTRW'(w_rel_n);
      r_commit_head <= w_commit_next;
      // Flush rewinds to the committed head including this cycle's commits.
      if (flush) begin
        r_spec_head <= w_commit_next;
      end else if (alloc_gnt) begin
        r_spec_head <= r_spec_head + PTRW'(w_alloc_n);
      end
      if (w_overflow || w_commit_bad || w_rel_bad) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
